bpsk_tx_sched: RTL and testbench

- Frame scheduler that sequences the carrier DDS for BPSK transmission.
- Accepts a frame request and a byte stream (valid/ready), then emits a preamble, the data bits MSB-first and a guard tail.
- Each symbol is held for SYM_LEN clocks.
- Drives the DDS phase offset (0 or 180 deg) and carrier enable; sits between the framing logic and the DDS phase accumulator.

---
 rtl/bpsk_pkg.sv | 18 +
 rtl/bpsk_tx_sched_sym_timer.sv | 30 +++
 rtl/bpsk_tx_sched.sv | 193 +++++++++++++++++++
 tb/tb_bpsk_tx_sched.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bpsk_pkg.sv
// Shared types and defaults for the BPSK transmit scheduler.
// Frame sequencing states and the 180-degree phase constant for a 32-bit DDS.
package bpsk_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2,
        TAIL     = 2'd3
    } state_t;

    localparam logic [31:0] PHASE_PI = 32'h8000_0000;

    localparam int DEF_SYM_LEN    = 100;
    localparam int DEF_PRE_BITS   = 32;
    localparam int DEF_GUARD_SYMS = 2;

endpackage

// File: rtl/bpsk_tx_sched_sym_timer.sv
// Symbol timer: counts clocks within a symbol while enabled.
// Flags the first cycle (strobe) and the last cycle (wrap) of each symbol.
module bpsk_sym_timer #(
    parameter int SYM_LEN = 100,
    parameter int CW      = $clog2(SYM_LEN)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          strobe,
    output logic          wrap
);

    localparam logic [CW-1:0] LAST = CW'(SYM_LEN - 1);

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt <= '0;
        end else if (wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign strobe = en && (cnt == '0);
    assign wrap   = en && (cnt == LAST);

endmodule

// File: rtl/bpsk_tx_sched.sv
// BPSK frame scheduler: preamble, MSB-first payload and guard tail,
// driving the DDS phase offset and carrier enable one symbol at a time.
module bpsk_tx_sched
    import bpsk_pkg::*;
#(
    parameter int SYM_LEN    = DEF_SYM_LEN,
    parameter int PRE_BITS   = DEF_PRE_BITS,
    parameter int GUARD_SYMS = DEF_GUARD_SYMS,
    parameter int PHASE_W    = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [7:0]         frame_len,
    input  logic [7:0]         byte_data,
    input  logic               byte_valid,
    output logic               byte_ready,
    output logic [PHASE_W-1:0] phase_off,
    output logic               sym_bit,
    output logic               sym_strobe,
    output logic               carrier_en,
    output logic               busy,
    output logic               done,
    output logic               underrun
);

    localparam int CW = $clog2(SYM_LEN);
    localparam int PW = $clog2(PRE_BITS + 1);
    localparam int GW = $clog2(GUARD_SYMS + 1);
    localparam logic [PW-1:0]      PRE_LAST   = PW'(PRE_BITS - 1);
    localparam logic [GW-1:0]      GUARD_LAST = GW'(GUARD_SYMS - 1);
    localparam logic [PHASE_W-1:0] PI_OFF     = {1'b1, {(PHASE_W-1){1'b0}}};

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] sym_cnt;
    logic          sym_wrap;
    logic [PW-1:0] pre_idx;
    logic [GW-1:0] guard_idx;
    logic [10:0]   data_cnt;
    logic [10:0]   data_total;
    logic [7:0]    len_reg;
    logic [7:0]    fetch_left;
    logic [7:0]    hold;
    logic          hold_full;
    logic [7:0]    shreg;
    logic          aborted;

    logic          frame_go;
    logic          accept;
    logic          pre_last;
    logic          data_last;
    logic          guard_last;
    logic          load_due;
    logic          have_byte;
    logic          bypass;
    logic          pop;
    logic          underrun_now;
    logic [7:0]    load_src;

    bpsk_sym_timer #(
        .SYM_LEN(SYM_LEN),
        .CW     (CW)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .en    (busy),
        .cnt   (sym_cnt),
        .strobe(sym_strobe),
        .wrap  (sym_wrap)
    );

    assign busy       = (state != IDLE);
    assign carrier_en = busy;
    assign byte_ready = !hold_full && (fetch_left != 8'd0)
                        && ((state == PREAMBLE) || (state == DATA));
    assign accept     = byte_valid && byte_ready;
    assign frame_go   = (state == IDLE) && start && (frame_len != 8'd0);

    assign data_total = {len_reg, 3'b000};
    assign pre_last   = (pre_idx == PRE_LAST);
    assign data_last  = (data_cnt == data_total - 11'd1);
    assign guard_last = (guard_idx == GUARD_LAST);

    // A byte load happens on the edge that starts the next data symbol group;
    // a byte arriving in that very cycle is passed straight into the shifter.
    assign load_due     = sym_wrap && (((state == PREAMBLE) && pre_last) ||
                          ((state == DATA) && (data_cnt[2:0] == 3'd7) && !data_last));
    assign have_byte    = hold_full || accept;
    assign load_src     = hold_full ? hold : byte_data;
    assign bypass       = load_due && !hold_full && accept;
    assign pop          = load_due && hold_full;
    assign underrun_now = load_due && !have_byte;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (frame_go) state_next = PREAMBLE;
            PREAMBLE: if (sym_wrap && pre_last) state_next = have_byte ? DATA : TAIL;
            DATA:     if (sym_wrap && (data_last || underrun_now)) state_next = TAIL;
            TAIL:     if (sym_wrap && guard_last) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        sym_bit = 1'b0;
        case (state)
            PREAMBLE: sym_bit = ~pre_idx[0];
            DATA:     sym_bit = shreg[7];
            default:  sym_bit = 1'b0;
        endcase
    end

    assign phase_off = sym_bit ? PI_OFF : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            len_reg    <= '0;
            fetch_left <= '0;
            hold       <= '0;
            hold_full  <= 1'b0;
            shreg      <= '0;
            pre_idx    <= '0;
            data_cnt   <= '0;
            guard_idx  <= '0;
            aborted    <= 1'b0;
            done       <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            done     <= 1'b0;
            underrun <= 1'b0;

            if (frame_go) begin
                len_reg    <= frame_len;
                fetch_left <= frame_len;
                hold_full  <= 1'b0;
                pre_idx    <= '0;
                data_cnt   <= '0;
                guard_idx  <= '0;
                aborted    <= 1'b0;
            end

            if (accept) begin
                fetch_left <= fetch_left - 8'd1;
            end
            if (accept && !bypass) begin
                hold      <= byte_data;
                hold_full <= 1'b1;
            end else if (pop) begin
                hold_full <= 1'b0;
            end

            if (load_due && have_byte) begin
                shreg <= load_src;
            end else if ((state == DATA) && sym_wrap) begin
                shreg <= {shreg[6:0], 1'b0};
            end

            if ((state == PREAMBLE) && sym_wrap) begin
                pre_idx <= pre_last ? '0 : pre_idx + 1'b1;
            end
            if ((state == DATA) && sym_wrap) begin
                data_cnt <= data_cnt + 11'd1;
            end

            // Starved load: the rest of the frame is abandoned, so stop fetching.
            if (underrun_now) begin
                aborted    <= 1'b1;
                fetch_left <= '0;
            end

            if ((state == TAIL) && sym_wrap) begin
                if (guard_last) begin
                    guard_idx <= '0;
                    done      <= 1'b1;
                    underrun  <= aborted;
                end else begin
                    guard_idx <= guard_idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bpsk_tx_sched.sv
// Self-checking bench for bpsk_tx_sched with short symbols and preamble.
// Frame vectors are table-driven; expected symbols flow through a queue.
module tb_bpsk_tx_sched
    import bpsk_pkg::*;
;

    localparam int SL = 4;
    localparam int PB = 4;
    localparam int GS = 1;

    typedef struct {
        logic [7:0]      len;
        logic [2:0][7:0] bytes;
        int              n_present;
        int              mode;
        int              off;
        bit              busy_start;
        bit              exp_ur;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  frame_len;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;
    logic [31:0] phase_off;
    logic        sym_bit;
    logic        sym_strobe;
    logic        carrier_en;
    logic        busy;
    logic        done;
    logic        underrun;

    int   checks = 0;
    int   errors = 0;
    logic exp_q[$];
    vec_t vecs[6];

    bpsk_tx_sched #(
        .SYM_LEN   (SL),
        .PRE_BITS  (PB),
        .GUARD_SYMS(GS),
        .PHASE_W   (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .frame_len (frame_len),
        .byte_data (byte_data),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .phase_off (phase_off),
        .sym_bit   (sym_bit),
        .sym_strobe(sym_strobe),
        .carrier_en(carrier_en),
        .busy      (busy),
        .done      (done),
        .underrun  (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk_vec(input logic [7:0] len, input logic [7:0] b0,
                                    input logic [7:0] b1, input logic [7:0] b2,
                                    input int n_present, input int mode, input int off,
                                    input bit busy_start, input bit exp_ur);
        vec_t v;
        v.len        = len;
        v.bytes      = {b2, b1, b0};
        v.n_present  = n_present;
        v.mode       = mode;
        v.off        = off;
        v.busy_start = busy_start;
        v.exp_ur     = exp_ur;
        return v;
    endfunction

    function automatic logic [63:0] all_outs();
        return 64'({phase_off, byte_ready, sym_bit, sym_strobe, carrier_en, busy, done, underrun});
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One whole frame: push the expected symbol stream, then walk it cycle by cycle.
    task automatic applyStimulus(input vec_t v);
        int   idx;
        int   sent;
        int   nsym;
        int   end_t;
        int   strobe_cnt;
        int   acc_t;
        int   pc;
        logic cur;

        exp_q.delete();
        for (int i = 0; i < PB; i++) exp_q.push_back((i % 2) == 0);
        sent = v.exp_ur ? v.n_present : int'(v.len);
        for (int b = 0; b < sent; b++)
            for (int k = 7; k >= 0; k--) exp_q.push_back(v.bytes[b][k]);
        for (int g = 0; g < GS; g++) exp_q.push_back(1'b0);
        nsym  = PB + 8 * sent + GS;
        end_t = nsym * SL;

        idx        = 0;
        strobe_cnt = 0;
        acc_t      = -10;
        cur        = 1'b0;
        byte_valid = 1'b0;
        frame_len  = v.len;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;

        for (int t = 0; t <= end_t; t++) begin
            pc = PB * SL - 1 - v.off + 8 * SL * idx;
            byte_data = (idx < 3) ? v.bytes[idx] : 8'h00;
            if (v.mode == 0) byte_valid = (idx < v.n_present);
            else             byte_valid = (idx < v.n_present) && (t == pc);
            start     = v.busy_start && (t == 10);
            frame_len = start ? 8'd3 : v.len;

            @(negedge clk);
            if (t < end_t) begin
                checkOutput("active_flags", 64'({busy, carrier_en, done, underrun}), 64'(4'b1100));
                checkOutput("strobe", 64'(sym_strobe), 64'((t % SL) == 0));
                if ((t % SL) == 0) begin
                    if (exp_q.size() == 0) checkOutput("queue_underflow", 64'(0), 64'(1));
                    else cur = exp_q.pop_front();
                end
                if (sym_strobe) strobe_cnt++;
                checkOutput("sym_bit", 64'(sym_bit), 64'(cur));
                checkOutput("phase_off", 64'(phase_off), 64'(cur ? PHASE_PI : 32'h0));
                if (v.mode == 1 && idx < v.n_present && t == pc)
                    checkOutput("ready_jit", 64'(byte_ready), 64'(1));
                if (v.mode == 1 && v.off == 1 && t == acc_t + 1)
                    checkOutput("ready_hold_full", 64'(byte_ready), 64'(0));
            end else begin
                checkOutput("end_flags", 64'({busy, carrier_en, done, underrun}),
                            64'({3'b001, v.exp_ur}));
                checkOutput("end_outputs", 64'({phase_off, sym_bit, sym_strobe, byte_ready}), 64'(0));
            end
            if (byte_valid && byte_ready) begin
                idx++;
                acc_t = t;
            end
            @(posedge clk);
            #1;
        end

        byte_valid = 1'b0;
        start      = 1'b0;
        @(negedge clk);
        checkOutput("done_pulse", 64'({done, underrun, busy}), 64'(0));
        checkOutput("strobe_cnt", 64'(strobe_cnt), 64'(nsym));
        checkOutput("queue_left", 64'(exp_q.size()), 64'(0));
        checkOutput("bytes_taken", 64'(idx), 64'(v.n_present));
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = mk_vec(8'd1, 8'hA5, 8'h00, 8'h00, 1, 0, 0, 1'b0, 1'b0);
        vecs[1] = mk_vec(8'd3, 8'h00, 8'hFF, 8'h0F, 3, 1, 1, 1'b0, 1'b0);
        vecs[2] = mk_vec(8'd2, 8'h3C, 8'h00, 8'h00, 1, 0, 0, 1'b0, 1'b1);
        vecs[3] = mk_vec(8'd2, 8'hC3, 8'h5A, 8'h00, 2, 1, 0, 1'b0, 1'b0);
        vecs[4] = mk_vec(8'd1, 8'h81, 8'h00, 8'h00, 0, 0, 0, 1'b0, 1'b1);
        vecs[5] = mk_vec(8'd1, 8'h5A, 8'h00, 8'h00, 1, 0, 0, 1'b1, 1'b0);

        rst        = 1'b1;
        start      = 1'b0;
        frame_len  = 8'd0;
        byte_data  = 8'h00;
        byte_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_outputs", all_outs(), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // A zero-length request must leave the scheduler idle.
        start      = 1'b1;
        frame_len  = 8'd0;
        byte_valid = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("len0_idle", 64'({busy, carrier_en, byte_ready, sym_strobe}), 64'(0));
            @(posedge clk);
            #1;
        end
        byte_valid = 1'b0;

        for (int i = 0; i < 6; i++) applyStimulus(vecs[i]);

        // Reset in the middle of the payload: everything drops, no done pulse.
        byte_data  = 8'h55;
        byte_valid = 1'b1;
        frame_len  = 8'd2;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int t = 0; t < 20; t++) @(posedge clk);
        @(negedge clk);
        checkOutput("mid_data_busy", 64'({busy, carrier_en}), 64'(2'b11));
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst        = 1'b0;
        byte_valid = 1'b0;
        @(negedge clk);
        checkOutput("rst_outputs", all_outs(), 64'(0));
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("rst_no_done", 64'({done, underrun, busy}), 64'(0));
        end
        @(posedge clk);
        #1;
        applyStimulus(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
